// File: rtl/pwr_rail_seq_if.sv
// Power rail sequencer bus.
// Groups the request/fault-clear controls, the rail power-good inputs and the
// sequencer status outputs so the sequencer and its controller share one port.
//   master : controller side (drives PWR_REQ, FAULT_CLR, RAIL_PG)
//   slave  : sequencer side (drives RAIL_EN and the SEQ_*/FAULT_RAIL status)
interface pwr_rail_seq_if #(
  parameter int unsigned NUM_RAILS = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_RAILS)
);
  logic                 PWR_REQ;
  logic                 FAULT_CLR;
  logic [NUM_RAILS-1:0] RAIL_PG;
  logic [NUM_RAILS-1:0] RAIL_EN;
  logic                 SEQ_PWROK;
  logic                 SEQ_FAULT;
  logic [IDX_W-1:0]     FAULT_RAIL;
  logic                 SEQ_BUSY;
  logic [2:0]           SEQ_STATE;

  modport master (
    output PWR_REQ, FAULT_CLR, RAIL_PG,
    input  RAIL_EN, SEQ_PWROK, SEQ_FAULT, FAULT_RAIL, SEQ_BUSY, SEQ_STATE
  );

  modport slave (
    input  PWR_REQ, FAULT_CLR, RAIL_PG,
    output RAIL_EN, SEQ_PWROK, SEQ_FAULT, FAULT_RAIL, SEQ_BUSY, SEQ_STATE
  );
endinterface

// File: rtl/pwr_rail_seq.sv
// N-rail power sequencer.
// Enables rails in ascending index order, each waiting for its power-good and
// then a settle delay; disables in descending order. A power-good timeout or
// loss while powering up / on latches a fault with the offending rail index.
// Ports:
//   CLK_33K_SUSCLK_PLD_R2 : only clock
//   RST_RSMRST            : synchronous active-high reset
//   bus (slave)           : PWR_REQ, FAULT_CLR, RAIL_PG in;
//                           RAIL_EN, SEQ_PWROK, SEQ_FAULT, FAULT_RAIL, SEQ_BUSY, SEQ_STATE out
module pwr_rail_seq #(
  parameter int unsigned NUM_RAILS  = 4,
  parameter int unsigned PG_TIMEOUT = 33,
  parameter int unsigned STEP_DLY   = 3,
  parameter int unsigned IDX_W      = $clog2(NUM_RAILS)
) (
  input logic           CLK_33K_SUSCLK_PLD_R2,
  input logic           RST_RSMRST,
  pwr_rail_seq_if.slave bus
);

  localparam int unsigned CNT_MAX_VAL = (PG_TIMEOUT > STEP_DLY) ? PG_TIMEOUT : STEP_DLY;
  localparam int unsigned CNT_W_RAW   = $clog2(CNT_MAX_VAL + 1);
  localparam int unsigned CNT_W       = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX_VAL);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_RAILS - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPwrUp = 3'd1,
    StOn    = 3'd2,
    StPwrDn = 3'd3,
    StFault = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  // 0: waiting on pg[idx], 1: settling after pg edge / timeout
  logic                 phase_q, phase_d;
  logic                 fault_q, fault_d;
  logic [IDX_W-1:0]     fault_rail_q, fault_rail_d;
  logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
  logic                 pwrok_q, pwrok_d;
  logic                 busy_q, busy_d;

  logic [NUM_RAILS-1:0] pg_meta_q, pg_q;
  logic                 pg_cur, pg_timeout, step_done;
  logic                 any_bad, below_bad;
  logic [IDX_W-1:0]     any_idx, below_idx;

  // Two-flop synchroniser for the asynchronous power-goods.
  always_ff @(posedge CLK_33K_SUSCLK_PLD_R2) begin
    if (RST_RSMRST) begin
      pg_meta_q <= '0;
      pg_q      <= '0;
    end else begin
      pg_meta_q <= bus.RAIL_PG;
      pg_q      <= pg_meta_q;
    end
  end

  assign pg_cur     = pg_q[idx_q];
  assign cnt_inc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
  // Decide on the cycle whose increment would reach the limit.
  assign pg_timeout = (32'(cnt_q) + 32'd1) >= PG_TIMEOUT;
  assign step_done  = (32'(cnt_q) + 32'd1) >= STEP_DLY;

  // Lowest-index missing power-good, overall and strictly below idx.
  always_comb begin
    any_bad   = 1'b0;
    any_idx   = '0;
    below_bad = 1'b0;
    below_idx = '0;
    for (int j = int'(NUM_RAILS) - 1; j >= 0; j--) begin
      if (!pg_q[j]) begin
        any_bad = 1'b1;
        any_idx = IDX_W'(j);
        if (j < int'(idx_q)) begin
          below_bad = 1'b1;
          below_idx = IDX_W'(j);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = '0;
    phase_d      = phase_q;
    fault_d      = fault_q;
    fault_rail_d = fault_rail_q;

    unique case (state_q)
      StIdle: begin
        phase_d = 1'b0;
        if (bus.PWR_REQ && !fault_q) begin
          state_d = StPwrUp;
          idx_d   = '0;
        end
      end

      StPwrUp: begin
        if (below_bad) begin
          state_d      = StFault;
          fault_d      = 1'b1;
          fault_rail_d = below_idx;
        end else if (!pg_cur && (phase_q || pg_timeout)) begin
          // pg lost while settling, or never arrived
          state_d      = StFault;
          fault_d      = 1'b1;
          fault_rail_d = idx_q;
        end else if (!bus.PWR_REQ) begin
          state_d = StPwrDn;
          phase_d = 1'b0;
        end else if (!phase_q) begin
          if (pg_cur) phase_d = 1'b1;
          else        cnt_d   = cnt_inc;
        end else if (step_done) begin
          phase_d = 1'b0;
          if (idx_q == IDX_LAST) state_d = StOn;
          else                   idx_d   = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StOn: begin
        if (any_bad) begin
          state_d      = StFault;
          fault_d      = 1'b1;
          fault_rail_d = any_idx;
        end else if (!bus.PWR_REQ) begin
          state_d = StPwrDn;
          idx_d   = IDX_LAST;
          phase_d = 1'b0;
        end
      end

      StPwrDn: begin
        // Losing pg here is the goal; a timeout just moves on without faulting.
        if (!phase_q) begin
          if (!pg_cur || pg_timeout) phase_d = 1'b1;
          else                       cnt_d   = cnt_inc;
        end else if (step_done) begin
          phase_d = 1'b0;
          if (idx_q == '0) state_d = StIdle;
          else             idx_d   = idx_q - IDX_W'(1);
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StFault: begin
        if (bus.FAULT_CLR && !bus.PWR_REQ) begin
          state_d      = StIdle;
          fault_d      = 1'b0;
          fault_rail_d = '0;
        end
      end

      default: begin
        state_d = StIdle;
        idx_d   = '0;
        phase_d = 1'b0;
      end
    endcase

    if (state_d == StFault || state_d == StIdle) begin
      idx_d   = '0;
      phase_d = 1'b0;
    end
  end

  // Outputs are registered from the next state so they change with it.
  always_comb begin
    rail_en_d = '0;
    for (int j = 0; j < int'(NUM_RAILS); j++) begin
      case (state_d)
        StPwrUp: rail_en_d[j] = (j <= int'(idx_d));
        StOn:    rail_en_d[j] = 1'b1;
        StPwrDn: rail_en_d[j] = (j < int'(idx_d));
        default: rail_en_d[j] = 1'b0;
      endcase
    end
    pwrok_d = (state_d == StOn);
    busy_d  = (state_d == StPwrUp) || (state_d == StPwrDn);
  end

  always_ff @(posedge CLK_33K_SUSCLK_PLD_R2) begin
    if (RST_RSMRST) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_rail_q <= '0;
      rail_en_q    <= '0;
      pwrok_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      fault_q      <= fault_d;
      fault_rail_q <= fault_rail_d;
      rail_en_q    <= rail_en_d;
      pwrok_q      <= pwrok_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.RAIL_EN    = rail_en_q;
  assign bus.SEQ_PWROK  = pwrok_q;
  assign bus.SEQ_FAULT  = fault_q;
  assign bus.FAULT_RAIL = fault_rail_q;
  assign bus.SEQ_BUSY   = busy_q;
  assign bus.SEQ_STATE  = state_q;

endmodule
